// File: rtl/stack_sequencer_if.sv
// Signal bundle between the decoder side, the stack pointer and byte-wide stack memory.
// The sequencer sits on the slave modport; whatever drives requests and memory uses master.
interface stack_sequencer_if;
  logic        push_req;
  logic        pop_req;
  logic [15:0] push_data;
  logic        mem_ready;
  logic [7:0]  mem_data_in;
  logic        sp_en;
  logic        sp_en_read;
  logic        sp_inr;
  logic        mem_wr;
  logic        mem_rd;
  logic [7:0]  mem_data_out;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] pop_data;

  modport slave (
    input  push_req, pop_req, push_data, mem_ready, mem_data_in,
    output sp_en, sp_en_read, sp_inr, mem_wr, mem_rd, mem_data_out,
    output busy, done, err, pop_data
  );

  modport master (
    output push_req, pop_req, push_data, mem_ready, mem_data_in,
    input  sp_en, sp_en_read, sp_inr, mem_wr, mem_rd, mem_data_out,
    input  busy, done, err, pop_data
  );
endinterface

// File: rtl/stack_sequencer.sv
// Splits a 16-bit register-pair PUSH/POP into two byte accesses, steering the
// external stack pointer and strobing byte-wide memory, with a per-access timeout.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for push_req / pop_req
// PSH_DEC_H | SP <- SP-1 ahead of the high-byte write
// PSH_WR_H  | write high byte at SP, wait for mem_ready
// PSH_DEC_L | SP <- SP-1 ahead of the low-byte write
// PSH_WR_L  | write low byte at SP, wait for mem_ready
// POP_RD_L  | read low byte at SP, wait for mem_ready
// POP_INC_L | SP <- SP+1
// POP_RD_H  | read high byte at SP, wait for mem_ready
// POP_INC_H | SP <- SP+1
// DONE      | one-cycle completion pulse, err reflects a timeout
module stack_sequencer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  stack_sequencer_if.slave  sif
);

  typedef enum logic [3:0] {
    IDLE, PSH_DEC_H, PSH_WR_H, PSH_DEC_L, PSH_WR_L,
    POP_RD_L, POP_INC_L, POP_RD_H, POP_INC_H, DONE
  } state_e;

  // The access aborts on the cycle the counter would reach MAX_WAIT.
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [3:0]  wait_q;
  logic [15:0] push_q;
  logic [7:0]  lo_q;
  logic [7:0]  hi_q;
  logic [15:0] pop_data_q;
  logic        err_q;
  logic        timeout;
  logic        in_access;
  logic        accept;

  logic        sp_en_q, sp_en_read_q, sp_inr_q;
  logic        mem_wr_q, mem_rd_q;
  logic [7:0]  mem_data_out_q;
  logic        busy_q, done_q;

  assign in_access = (state_q == PSH_WR_H) || (state_q == PSH_WR_L) ||
                     (state_q == POP_RD_L) || (state_q == POP_RD_H);
  assign accept    = (state_q == IDLE) && (sif.push_req || sif.pop_req);

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (sif.push_req)     state_d = PSH_DEC_H;
        else if (sif.pop_req) state_d = POP_RD_L;
      end
      PSH_DEC_H: state_d = PSH_WR_H;
      PSH_DEC_L: state_d = PSH_WR_L;
      POP_INC_L: state_d = POP_RD_H;
      POP_INC_H: state_d = DONE;
      PSH_WR_H, PSH_WR_L, POP_RD_L, POP_RD_H: begin
        if (sif.mem_ready) begin
          case (state_q)
            PSH_WR_H: state_d = PSH_DEC_L;
            PSH_WR_L: state_d = DONE;
            POP_RD_L: state_d = POP_INC_L;
            default:  state_d = POP_INC_H;
          endcase
        end else if (wait_q == WAIT_LAST) begin
          state_d = DONE;
          timeout = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      wait_q         <= '0;
      push_q         <= '0;
      lo_q           <= '0;
      hi_q           <= '0;
      pop_data_q     <= '0;
      err_q          <= 1'b0;
      sp_en_q        <= 1'b0;
      sp_en_read_q   <= 1'b0;
      sp_inr_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      mem_rd_q       <= 1'b0;
      mem_data_out_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q <= state_d;

      // Every access state is entered from a different state, so a state
      // change is exactly the point to restart the wait count.
      if (state_d != state_q)
        wait_q <= '0;
      else if (in_access && !sif.mem_ready)
        wait_q <= wait_q + 4'd1;

      if (state_q == IDLE && sif.push_req)
        push_q <= sif.push_data;

      if (accept)
        err_q <= 1'b0;
      else if (timeout)
        err_q <= 1'b1;

      if (state_q == POP_RD_L && sif.mem_ready)
        lo_q <= sif.mem_data_in;
      if (state_q == POP_RD_H && sif.mem_ready)
        hi_q <= sif.mem_data_in;

      // POP_INC_H can only exit into DONE after both reads succeeded.
      if (state_q == POP_INC_H)
        pop_data_q <= {hi_q, lo_q};

      sp_en_q        <= (state_d != IDLE) && (state_d != DONE);
      sp_en_read_q   <= (state_d == PSH_DEC_H) || (state_d == PSH_DEC_L) ||
                        (state_d == POP_INC_L) || (state_d == POP_INC_H);
      sp_inr_q       <= (state_d == POP_INC_L) || (state_d == POP_INC_H);
      mem_wr_q       <= (state_d == PSH_WR_H) || (state_d == PSH_WR_L);
      mem_rd_q       <= (state_d == POP_RD_L) || (state_d == POP_RD_H);
      mem_data_out_q <= (state_d == PSH_WR_H) ? push_q[15:8] :
                        (state_d == PSH_WR_L) ? push_q[7:0]  : 8'h00;
      busy_q         <= (state_d != IDLE);
      done_q         <= (state_d == DONE);
    end
  end

  assign sif.sp_en        = sp_en_q;
  assign sif.sp_en_read   = sp_en_read_q;
  assign sif.sp_inr       = sp_inr_q;
  assign sif.mem_wr       = mem_wr_q;
  assign sif.mem_rd       = mem_rd_q;
  assign sif.mem_data_out = mem_data_out_q;
  assign sif.busy         = busy_q;
  assign sif.done         = done_q;
  assign sif.err          = err_q;
  assign sif.pop_data     = pop_data_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: models the stack pointer and memory, predicts each
// operation's outcome at request time and checks it when the DUT reports done.
module tb_stack_sequencer;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    int          done_cyc;
    logic        err;
    logic [15:0] pop;
    logic [15:0] sp;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  stack_sequencer_if sif();

  stack_sequencer #(.MAX_WAIT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [15:0] sp = 16'h00FA;
  bit   [7:0]  dev_mem [0:65535];
  bit   [7:0]  ref_mem [0:65535];
  logic [15:0] ref_sp = 16'h00FA;
  logic [15:0] ref_pop = 16'h0000;
  logic        cur_err;
  logic [15:0] cur_pop;

  wr_t  wq[$];
  exp_t dq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  assign sif.mem_data_in = sif.mem_rd ? dev_mem[sp] : 8'h00;

  // Stack pointer and memory device
  always @(posedge clk) begin
    if (sif.mem_wr && sif.mem_ready) begin
      dev_mem[sp] <= sif.mem_data_out;
      if (wq.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        check("wr_addr", {16'h0, sp}, {16'h0, w.addr});
        check("wr_data", {24'h0, sif.mem_data_out}, {24'h0, w.data});
      end
    end
    if (sif.sp_en && sif.sp_en_read)
      sp <= sif.sp_inr ? sp + 16'd1 : sp - 16'd1;
  end

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      cur_err = 1'b0;
      cur_pop = 16'h0;
    end else begin
      if (!sif.mem_wr)
        check("dout_zero", {24'h0, sif.mem_data_out}, 32'h0);
      else if (wq.size() > 0) begin
        check("wr_hold_data", {24'h0, sif.mem_data_out}, {24'h0, wq[0].data});
        check("wr_hold_addr", {16'h0, sp}, {16'h0, wq[0].addr});
      end
      if (sif.done) begin
        if (dq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = dq.pop_front();
          check("latency", cyc, e.done_cyc);
          check("err", {31'h0, sif.err}, {31'h0, e.err});
          check("pop_data", {16'h0, sif.pop_data}, {16'h0, e.pop});
          check("sp_final", {16'h0, sp}, {16'h0, e.sp});
          check("busy_in_done", {31'h0, sif.busy}, 32'h1);
          cur_err = e.err;
          cur_pop = e.pop;
        end
      end else if (sif.busy) begin
        if (dq.size() == 0) check("unexpected_busy", 32'd1, 32'd0);
        check("err_busy", {31'h0, sif.err}, 32'h0);
        check("pop_hold", {16'h0, sif.pop_data}, {16'h0, cur_pop});
      end else begin
        check("idle_outs", {27'h0, sif.sp_en, sif.sp_en_read, sif.sp_inr, sif.mem_wr, sif.mem_rd}, 32'h0);
        check("idle_err", {31'h0, sif.err}, {31'h0, cur_err});
        check("idle_pop", {16'h0, sif.pop_data}, {16'h0, cur_pop});
      end
    end
  end

  // Reference model: outcome of one accepted operation from the stack rules.
  // A wait count of 15 or more means memory never answers that access.
  task automatic model_txn(input bit is_push, input logic [15:0] data,
                           input int w1, input int w2, input int req_cyc);
    exp_t e;
    int lat;
    logic [7:0] lo, hi;
    e.err = 1'b0;
    if (is_push) begin
      ref_sp = ref_sp - 16'd1;
      if (w1 >= 15) begin
        lat = 16; e.err = 1'b1;
      end else begin
        ref_mem[ref_sp] = data[15:8];
        wq.push_back('{addr: ref_sp, data: data[15:8]});
        ref_sp = ref_sp - 16'd1;
        if (w2 >= 15) begin
          lat = 18 + w1; e.err = 1'b1;
        end else begin
          ref_mem[ref_sp] = data[7:0];
          wq.push_back('{addr: ref_sp, data: data[7:0]});
          lat = 4 + w1 + w2;
        end
      end
    end else begin
      if (w1 >= 15) begin
        lat = 15; e.err = 1'b1;
      end else begin
        lo = ref_mem[ref_sp];
        ref_sp = ref_sp + 16'd1;
        if (w2 >= 15) begin
          lat = 17 + w1; e.err = 1'b1;
        end else begin
          hi = ref_mem[ref_sp];
          ref_sp = ref_sp + 16'd1;
          ref_pop = {hi, lo};
          lat = 4 + w1 + w2;
        end
      end
    end
    e.pop = ref_pop;
    e.sp = ref_sp;
    e.done_cyc = req_cyc + 1 + lat;
    dq.push_back(e);
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (sif.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_txn(input bit do_push, input bit do_pop, input logic [15:0] data,
                         input int w1, input int w2, input bit noise);
    int acc_idx = 0;
    int wc = 0;
    int n = 0;
    int w;
    bit seen = 0;
    wait_idle();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    sif.push_req = do_push;
    sif.pop_req = do_pop;
    sif.push_data = data;
    if (do_push || do_pop) model_txn(do_push, data, w1, w2, cyc);
    @(negedge clk);
    sif.push_req = 1'b0;
    sif.pop_req = 1'b0;
    sif.push_data = 16'($urandom);
    if (!(do_push || do_pop)) return;
    while (!seen && n < 80) begin
      if (sif.done) begin
        seen = 1;
      end else begin
        if (sif.mem_wr || sif.mem_rd) begin
          w = (acc_idx == 0) ? w1 : w2;
          if (wc < w) begin
            sif.mem_ready = 1'b0;
            wc++;
          end else begin
            sif.mem_ready = 1'b1;
            acc_idx++;
            wc = 0;
          end
        end else begin
          sif.mem_ready = 1'($urandom_range(0, 1));
        end
        if (noise && sif.busy) begin
          sif.push_req = 1'($urandom_range(0, 1));
          sif.pop_req = 1'($urandom_range(0, 1));
          sif.push_data = 16'($urandom);
        end
        @(negedge clk);
        n++;
      end
    end
    sif.push_req = 1'b0;
    sif.pop_req = 1'b0;
    sif.mem_ready = 1'b0;
    if (!seen) begin
      check("done_timeout", 32'd1, 32'd0);
      dq.delete();
    end
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(0, 3);
    if (r == 6) return 14;
    if (r == 7) return 15;
    return $urandom_range(0, 14);
  endfunction

  initial begin
    sif.push_req = 1'b0;
    sif.pop_req = 1'b0;
    sif.push_data = 16'h0;
    sif.mem_ready = 1'b0;
    #12;
    check("rst_outs", {24'h0, sif.sp_en, sif.sp_en_read, sif.sp_inr, sif.mem_wr,
                       sif.mem_rd, sif.busy, sif.done, sif.err}, 32'h0);
    check("rst_data", {8'h0, sif.mem_data_out, sif.pop_data}, 32'h0);
    #15 reset = 1'b1;

    run_txn(1, 0, 16'h1234, 0, 0, 0);
    run_txn(0, 1, 16'h0000, 0, 0, 0);
    run_txn(1, 0, 16'h1234, 3, 0, 0);
    run_txn(0, 1, 16'h0000, 15, 0, 0);
    run_txn(1, 1, 16'hABCD, 0, 0, 1);
    run_txn(1, 0, 16'h5566, 14, 14, 0);
    run_txn(0, 1, 16'h0000, 2, 15, 0);
    run_txn(1, 0, 16'h7788, 1, 15, 0);
    run_txn(1, 0, 16'h99AA, 15, 0, 1);

    // Reset while in PSH_DEC_L: high byte already written, SP moved by one.
    wait_idle();
    sif.push_req = 1'b1;
    sif.push_data = 16'h5A3C;
    ref_sp = ref_sp - 16'd1;
    ref_mem[ref_sp] = 8'h5A;
    wq.push_back('{addr: ref_sp, data: 8'h5A});
    dq.push_back('{done_cyc: 0, err: 1'b0, pop: 16'h0, sp: 16'h0});
    @(negedge clk);
    sif.push_req = 1'b0;
    sif.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_outs", {24'h0, sif.sp_en, sif.sp_en_read, sif.sp_inr, sif.mem_wr,
                           sif.mem_rd, sif.busy, sif.done, sif.err}, 32'h0);
    check("rst_mid_data", {8'h0, sif.mem_data_out, sif.pop_data}, 32'h0);
    check("rst_mid_sp", {16'h0, sp}, {16'h0, ref_sp});
    dq.delete();
    ref_pop = 16'h0;
    sif.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    run_txn(1, 0, 16'hC0DE, 0, 1, 0);
    run_txn(0, 1, 16'h0000, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      bit pu, po;
      pu = 1'($urandom_range(0, 1));
      po = pu ? 1'($urandom_range(0, 3) == 0) : 1'b1;
      run_txn(pu, po, 16'($urandom), pick_wait(), pick_wait(), 1'($urandom_range(0, 1)));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("dq_empty", dq.size(), 32'd0);
    check("wq_empty", wq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Initiator side of the stack interface: sequences 16-bit register-pair PUSH/POP as two byte accesses to 8-bit memory.
- Drives the stack pointer's control inputs (en, en_read, inr_sp); the stack pointer drives the address bus.
- Drives memory write/read strobes and write data, and assembles popped bytes.
- Sits between the instruction decoder and the stack pointer and memory, in place of the decoder driving those strobes directly.

Parameters:
- MAX_WAIT, 15, cycles a memory-access state may wait for mem_ready before aborting (4-bit wait counter; legal range 1-15).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- push_req  input  1  start PUSH of push_data; sampled in IDLE only.
- pop_req  input  1  start POP; sampled in IDLE only.
- push_data  input  16  pair to push; [15:8] high byte, [7:0] low byte; captured when the request is accepted.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_data_in  input  8  read data; valid in a read state when mem_ready=1.
- sp_en  output  1  to stack pointer en.
- sp_en_read  output  1  to stack pointer en_read (1 = update SP, 0 = drive address).
- sp_inr  output  1  to stack pointer inr_sp (1 = increment, 0 = decrement).
- mem_wr  output  1  memory write strobe.
- mem_rd  output  1  memory read strobe.
- mem_data_out  output  8  write data; 0 when mem_wr=0.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  last operation aborted on timeout; sticky until the next accepted request.
- pop_data  output  16  last successfully popped pair; holds its value otherwise.

Behaviour:
- States: IDLE, PSH_DEC_H, PSH_WR_H, PSH_DEC_L, PSH_WR_L, POP_RD_L, POP_INC_L, POP_RD_H, POP_INC_H, DONE.
- Reset (asynchronous, mid-operation included): state returns to IDLE. All outputs 0, pop_data=0, err=0, latches and wait counter cleared. No rollback of any SP movement already made.
- IDLE acceptance:
  - push_req=1: latch push_data, clear err, go to PSH_DEC_H.
  - else pop_req=1: clear err, go to POP_RD_L.
  - Both requests high: PUSH wins; pop_req is dropped, not queued.
- Requests outside IDLE (including DONE) are ignored.
- Output decode from state register (Moore):
  - DEC states: sp_en=1, sp_en_read=1, sp_inr=0.
  - INC states: sp_en=1, sp_en_read=1, sp_inr=1.
  - PSH_WR_H/PSH_WR_L: sp_en=1, sp_en_read=0, mem_wr=1, mem_data_out=high/low byte.
  - POP_RD_L/POP_RD_H: sp_en=1, sp_en_read=0, mem_rd=1.
  - All other states: these outputs 0.
- DEC/INC states last exactly one cycle; the SP updates on the edge that leaves them.
- Access states hold (outputs stable) while mem_ready=0 and advance on the edge where mem_ready=1.
  - Read states capture mem_data_in on that edge: low byte in POP_RD_L, high byte in POP_RD_H.
- Sequences:
  - PUSH: DEC_H, WR_H, DEC_L, WR_L, DONE. High byte goes to SP-1, low byte to SP-2, final SP = SP-2.
  - POP: RD_L, INC_L, RD_H, INC_H, DONE. Final SP = SP+2.
- Latency (zero waits): 4 cycles from acceptance edge to DONE. done=1 for exactly one cycle in DONE. busy=1 in DONE. DONE always returns to IDLE.
- pop_data is updated with {high,low} on entry to DONE, and only after a successful POP.
- Wait counter:
  - Cleared on entering each access state.
  - Increments each cycle mem_ready=0 in an access state.
  - If it reaches MAX_WAIT with mem_ready still 0: go to DONE, err=1, done pulses, pop_data unchanged, SP left as-is.
- mem_ready in non-access states is ignored.

Test Plan:
- Reset, SP=0x00FA, push_data=0x1234, push_req 1 cycle, mem_ready=1 -> writes 0x12@0x00F9 then 0x34@0x00F8; done pulses 4 cycles after acceptance; SP=0x00F8; err=0.
- After that, pop_req, memory returns the stored bytes -> reads 0x00F8 then 0x00F9; pop_data=0x1234; SP=0x00FA; done one cycle.
- PUSH with mem_ready low 3 cycles in PSH_WR_H -> mem_wr and mem_data_out=0x12 held 4 cycles; total 7 cycles to done; no err.
- POP with mem_ready stuck 0, MAX_WAIT=15 -> after 15 wait cycles go to DONE, err=1, pop_data unchanged; next push_req clears err.
- push_req and pop_req high together in IDLE, push_data=0xABCD -> PUSH executes; no POP follows; requests during busy ignored.
- reset asserted in PSH_DEC_L -> immediately IDLE, all outputs 0, no further mem_wr; subsequent PUSH runs normally.
